// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer that drives the
// Computational_unit datapath: FSM states, instruction opcode prefixes,
// register/source codes, data_bus select codes and reg_en bit positions.
// No ports (package).
package cpu_ctrl_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_JADDR,
        ST_JLOAD
    } state_t;

    // Opcode prefixes, matched against the top bits of ir
    localparam logic       OP_LDI_PFX = 1'b0;
    localparam logic [1:0] OP_MOV_PFX = 2'b10;
    localparam logic [2:0] OP_ALU_PFX = 3'b110;
    localparam logic [7:0] OP_JMP     = 8'hE0;
    localparam logic [7:0] OP_JNZ     = 8'hE1;

    // Register codes used in dst/src fields
    localparam logic [2:0] CODE_X0   = 3'd0;
    localparam logic [2:0] CODE_X1   = 3'd1;
    localparam logic [2:0] CODE_Y0   = 3'd2;
    localparam logic [2:0] CODE_Y1   = 3'd3;
    localparam logic [2:0] DST_OREG  = 3'd4;
    localparam logic [2:0] SRC_R     = 3'd4;
    localparam logic [2:0] CODE_M    = 3'd5;
    localparam logic [2:0] CODE_I    = 3'd6;
    localparam logic [2:0] CODE_DM   = 3'd7;

    // data_bus source select codes beyond the plain register sources 0..7
    localparam logic [3:0] SEL_IMM   = 4'd8;
    localparam logic [3:0] SEL_IPINS = 4'd9;
    localparam logic [3:0] SEL_ZERO  = 4'd10;

    // reg_en bit positions
    localparam int RE_X0   = 0;
    localparam int RE_X1   = 1;
    localparam int RE_Y0   = 2;
    localparam int RE_Y1   = 3;
    localparam int RE_R    = 4;
    localparam int RE_M    = 5;
    localparam int RE_I    = 6;
    localparam int RE_DM   = 7;
    localparam int RE_OREG = 8;

    // Destination code to reg_en one-hot. Every code except o_reg already
    // equals its reg_en bit position, so only o_reg needs remapping.
    function automatic logic [8:0] dst_onehot(input logic [2:0] dst);
        logic [8:0] oh;
        oh = '0;
        case (dst)
            DST_OREG: oh[RE_OREG] = 1'b1;
            default:  oh[dst]     = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder.
// Ports:
//   ir         in   8  latched instruction
//   source_sel out  4  data_bus mux select
//   reg_en     out  9  register write enables
//   i_sel      out  1  1: i <= i+m (post-increment), 0: i <= data_bus
//   x_sel      out  1  ALU x operand select
//   y_sel      out  1  ALU y operand select
//   is_jmp     out  1  instruction is JMP
//   is_jnz     out  1  instruction is JNZ
// Outputs are ungated; the sequencer only lets them through during EXEC.
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [3:0]         source_sel,
    output logic [8:0]         reg_en,
    output logic               i_sel,
    output logic               x_sel,
    output logic               y_sel,
    output logic               is_jmp,
    output logic               is_jnz
);

    logic [2:0] ldi_dst;
    logic [2:0] mov_dst;
    logic [2:0] mov_src;

    assign ldi_dst = ir[6:4];
    assign mov_dst = ir[5:3];
    assign mov_src = ir[2:0];

    // Decode by prefix. Any access to dm bumps the index register i,
    // except when i itself is being written, in which case the bus value wins.
    always_comb begin
        source_sel = SEL_ZERO;
        reg_en     = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        is_jmp     = 1'b0;
        is_jnz     = 1'b0;
        if (ir[7] == OP_LDI_PFX) begin
            source_sel = SEL_IMM;
            reg_en     = dst_onehot(ldi_dst);
            if (ldi_dst == CODE_DM) begin
                reg_en[RE_I] = 1'b1;
                i_sel        = 1'b1;
            end
        end else if (ir[7:6] == OP_MOV_PFX) begin
            reg_en     = dst_onehot(mov_dst);
            source_sel = (mov_dst == mov_src) ? SEL_IPINS : {1'b0, mov_src};
            if ((mov_dst == CODE_DM) || (mov_src == CODE_DM)) begin
                reg_en[RE_I] = 1'b1;
                i_sel        = (mov_dst != CODE_I);
            end
        end else if (ir[7:5] == OP_ALU_PFX) begin
            x_sel        = ir[4];
            y_sel        = ir[3];
            reg_en[RE_R] = 1'b1;
        end else begin
            is_jmp = (ir == OP_JMP);
            is_jnz = (ir == OP_JNZ);
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/sequence unit for the Computational_unit datapath.
// Ports:
//   clk         in   1     clock, all state on posedge
//   sync_reset  in   1     synchronous active-high reset
//   pm_addr     out  8     program ROM address (ROM answers one cycle later)
//   pm_data     in   8     program ROM read data
//   r_eq_0      in   1     datapath zero flag, used by JNZ
//   nibble_ir   out  4     ir[3:0], ALU function / immediate
//   source_sel  out  4     data_bus mux select (10 = constant zero)
//   reg_en      out  9     register write enables
//   i_sel       out  1     index register update select
//   x_sel       out  1     ALU x operand select
//   y_sel       out  1     ALU y operand select
//   pc          out  8     current program counter
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               sync_reset,
    output logic [PC_W-1:0]    pm_addr,
    input  logic [INSTR_W-1:0] pm_data,
    input  logic               r_eq_0,
    output logic [3:0]         nibble_ir,
    output logic [3:0]         source_sel,
    output logic [8:0]         reg_en,
    output logic               i_sel,
    output logic               x_sel,
    output logic               y_sel,
    output logic [PC_W-1:0]    pc
);

    state_t             state;
    state_t             state_next;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] ir_next;
    logic [PC_W-1:0]    pc_next;

    logic [3:0] dec_source_sel;
    logic [8:0] dec_reg_en;
    logic       dec_i_sel;
    logic       dec_x_sel;
    logic       dec_y_sel;
    logic       dec_is_jmp;
    logic       dec_is_jnz;
    logic       jump_taken;
    logic       exec_active;

    instr_decode u_decode (
        .ir         (ir),
        .source_sel (dec_source_sel),
        .reg_en     (dec_reg_en),
        .i_sel      (dec_i_sel),
        .x_sel      (dec_x_sel),
        .y_sel      (dec_y_sel),
        .is_jmp     (dec_is_jmp),
        .is_jnz     (dec_is_jnz)
    );

    // State, pc and instruction registers
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state <= ST_FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    assign jump_taken = dec_is_jmp || (dec_is_jnz && !r_eq_0);

    // Sequencing. pc already points at the address byte once a jump reaches
    // JADDR; a not-taken JNZ steps over that byte. pc wraps naturally at 8 bits.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        case (state)
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                ir_next    = pm_data;
                pc_next    = pc + 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = (dec_is_jmp || dec_is_jnz) ? ST_JADDR : ST_FETCH;
            end
            ST_JADDR: begin
                state_next = ST_JLOAD;
            end
            ST_JLOAD: begin
                pc_next    = jump_taken ? pm_data : pc + 1'b1;
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Controls reach the datapath for the single EXEC cycle only, and are
    // held idle combinationally while reset is asserted.
    assign exec_active = (state == ST_EXEC) && !sync_reset;
    assign pm_addr     = pc;
    assign nibble_ir   = ir[3:0];
    assign reg_en      = exec_active ? dec_reg_en     : '0;
    assign source_sel  = exec_active ? dec_source_sel : SEL_ZERO;
    assign i_sel       = exec_active && dec_i_sel;
    assign x_sel       = exec_active && dec_x_sel;
    assign y_sel       = exec_active && dec_y_sel;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. A behavioural synchronous ROM
// feeds pm_data; each scenario loads a program, pushes the expected EXEC
// controls and fetch addresses (tagged with their cycle after reset release)
// onto a scoreboard and pops them as the run reaches those cycles.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       r_eq_0 = 1'b0;
    logic [7:0] pm_addr;
    logic [7:0] pm_data;
    logic [7:0] pc;
    logic [3:0] nibble_ir;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;

    logic [7:0] rom [256];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] cyc;
        logic [35:0] val;
        logic [35:0] mask;
        logic [63:0] name;
    } exp_t;

    exp_t sb[$];

    localparam logic [35:0] CTRL_MASK = 36'hFFFFF0000;
    localparam logic [35:0] ADDR_MASK = 36'h00000FFFF;

    control_sequencer dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .pm_addr    (pm_addr),
        .pm_data    (pm_data),
        .r_eq_0     (r_eq_0),
        .nibble_ir  (nibble_ir),
        .source_sel (source_sel),
        .reg_en     (reg_en),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pm_data <= rom[pm_addr];

    function automatic logic [35:0] obs_vec();
        return {reg_en, source_sel, i_sel, x_sel, y_sel, nibble_ir, pm_addr, pc};
    endfunction

    function automatic exp_t mk_exec(input int c, input logic [8:0] re, input logic [3:0] ss,
                                     input logic is, input logic xs, input logic ys,
                                     input logic [3:0] nib, input logic [63:0] nm);
        exp_t e;
        e.cyc  = c[15:0];
        e.val  = {re, ss, is, xs, ys, nib, 16'h0000};
        e.mask = CTRL_MASK;
        e.name = nm;
        return e;
    endfunction

    function automatic exp_t mk_fetch(input int c, input logic [7:0] addr, input logic [63:0] nm);
        exp_t e;
        e.cyc  = c[15:0];
        e.val  = {20'h00000, addr, addr};
        e.mask = ADDR_MASK;
        e.name = nm;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 8'hF0;
        sb.delete();
    endtask

    // Two reset cycles; on return the current cycle is cycle 0 (first FETCH)
    task automatic do_reset();
        sync_reset = 1'b1;
        step();
        step();
        sync_reset = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        clear_rom();
        rom[0] = 8'hE0;
        rom[1] = 8'h30;
        sync_reset = 1'b1;
        step();
        step();
        total++;
        if ({pc, reg_en, source_sel} !== {8'h00, 9'h000, 4'd10}) begin
            bad++;
            $display("[TB] FAIL reset_idle got=%h want=%h", {pc, reg_en, source_sel}, {8'h00, 9'h000, 4'd10});
        end
        sync_reset = 1'b0;
        for (int c = 0; c < 3; c++) step();
        total++;
        if (pm_addr !== 8'h01) begin
            bad++;
            $display("[TB] FAIL jaddr_pos got=%h want=01", pm_addr);
        end
        sync_reset = 1'b1;
        step();
        step();
        total++;
        if ({pc, reg_en, source_sel, i_sel} !== {8'h00, 9'h000, 4'd10, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_mid_jump got=%h want=%h", {pc, reg_en, source_sel, i_sel},
                     {8'h00, 9'h000, 4'd10, 1'b0});
        end
        sync_reset = 1'b0;
        total++;
        if (pm_addr !== 8'h00) begin
            bad++;
            $display("[TB] FAIL first_fetch got=%h want=00", pm_addr);
        end
        for (int c = 0; c < 5; c++) step();
        total++;
        if (pm_addr !== 8'h30) begin
            bad++;
            $display("[TB] FAIL replay_jump got=%h want=30", pm_addr);
        end
        clear_rom();
        rom[0] = 8'h05;
        do_reset();
        step();
        step();
        total++;
        if (reg_en !== 9'h001) begin
            bad++;
            $display("[TB] FAIL exec_before_reset got=%h want=001", reg_en);
        end
        sync_reset = 1'b1;
        #1;
        total++;
        if ({reg_en, source_sel} !== {9'h000, 4'd10}) begin
            bad++;
            $display("[TB] FAIL reset_in_exec got=%h want=%h", {reg_en, source_sel}, {9'h000, 4'd10});
        end
        step();
        step();
        sync_reset = 1'b0;
    endtask

    task automatic test_ldi_mov_alu();
        exp_t e;
        $display("[TB] test_ldi_mov_alu");
        clear_rom();
        rom[0] = 8'h05;
        rom[1] = 8'h87;
        rom[2] = 8'hB7;
        rom[3] = 8'h80;
        rom[4] = 8'hD2;
        r_eq_0 = 1'b0;
        do_reset();
        sb.push_back(mk_fetch(0, 8'h00, "fetch0"));
        sb.push_back(mk_exec(1, 9'h000, 4'd10, 1'b0, 1'b0, 1'b0, 4'h0, "decidle"));
        sb.push_back(mk_exec(2, 9'h001, 4'd8, 1'b0, 1'b0, 1'b0, 4'h5, "ldi_x0"));
        sb.push_back(mk_fetch(3, 8'h01, "fetch1"));
        sb.push_back(mk_exec(4, 9'h000, 4'd10, 1'b0, 1'b0, 1'b0, 4'h5, "dec2idle"));
        sb.push_back(mk_exec(5, 9'h041, 4'd7, 1'b1, 1'b0, 1'b0, 4'h7, "mov_x0dm"));
        sb.push_back(mk_exec(8, 9'h040, 4'd7, 1'b0, 1'b0, 1'b0, 4'h7, "mov_i_dm"));
        sb.push_back(mk_exec(11, 9'h001, 4'd9, 1'b0, 1'b0, 1'b0, 4'h0, "mov_pins"));
        sb.push_back(mk_exec(14, 9'h010, 4'd10, 1'b0, 1'b1, 1'b0, 4'h2, "alu_add"));
        sb.push_back(mk_fetch(15, 8'h05, "fetch5"));
        for (int c = 0; c < 16; c++) begin
            while (sb.size() != 0 && int'(sb[0].cyc) == c) begin
                e = sb.pop_front();
                total++;
                if ((obs_vec() & e.mask) !== (e.val & e.mask)) begin
                    bad++;
                    $display("[TB] FAIL %0s cyc=%0d got=%h want=%h", e.name, c, obs_vec() & e.mask, e.val & e.mask);
                end
            end
            step();
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL ldi_leftover got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        $display("[TB] test_back_to_back");
        clear_rom();
        rom[0] = 8'h7A;
        rom[1] = 8'h43;
        rom[2] = 8'h6C;
        rom[3] = 8'hBE;
        rom[4] = 8'hF5;
        rom[5] = 8'hE7;
        do_reset();
        sb.push_back(mk_exec(2, 9'h0C0, 4'd8, 1'b1, 1'b0, 1'b0, 4'hA, "ldi_dm"));
        sb.push_back(mk_exec(5, 9'h100, 4'd8, 1'b0, 1'b0, 1'b0, 4'h3, "ldi_oreg"));
        sb.push_back(mk_exec(8, 9'h040, 4'd8, 1'b0, 1'b0, 1'b0, 4'hC, "ldi_i"));
        sb.push_back(mk_exec(11, 9'h0C0, 4'd6, 1'b1, 1'b0, 1'b0, 4'hE, "mov_dm_i"));
        sb.push_back(mk_exec(14, 9'h000, 4'd10, 1'b0, 1'b0, 1'b0, 4'h5, "nop_f5"));
        sb.push_back(mk_exec(17, 9'h000, 4'd10, 1'b0, 1'b0, 1'b0, 4'h7, "nop_e7"));
        sb.push_back(mk_fetch(18, 8'h06, "fetch6"));
        for (int c = 0; c < 19; c++) begin
            while (sb.size() != 0 && int'(sb[0].cyc) == c) begin
                e = sb.pop_front();
                total++;
                if ((obs_vec() & e.mask) !== (e.val & e.mask)) begin
                    bad++;
                    $display("[TB] FAIL %0s cyc=%0d got=%h want=%h", e.name, c, obs_vec() & e.mask, e.val & e.mask);
                end
            end
            step();
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL b2b_leftover got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_jnz();
        exp_t e;
        logic taken;
        $display("[TB] test_jnz");
        for (int r = 0; r < 2; r++) begin
            clear_rom();
            rom[8'h00] = 8'hE0;
            rom[8'h01] = 8'h10;
            rom[8'h10] = 8'hE1;
            rom[8'h11] = 8'h40;
            rom[8'h12] = 8'h01;
            rom[8'h40] = 8'h02;
            r_eq_0 = r[0];
            taken  = (r == 0);
            do_reset();
            sb.push_back(mk_exec(2, 9'h000, 4'd10, 1'b0, 1'b0, 1'b0, 4'h0, "jmp_idle"));
            sb.push_back(mk_fetch(3, 8'h01, "jmp_addr"));
            sb.push_back(mk_fetch(5, 8'h10, "fetch10"));
            sb.push_back(mk_exec(7, 9'h000, 4'd10, 1'b0, 1'b0, 1'b0, 4'h1, "jnz_idle"));
            sb.push_back(mk_fetch(8, 8'h11, "jnz_addr"));
            sb.push_back(mk_fetch(10, taken ? 8'h40 : 8'h12, "jnz_tgt"));
            sb.push_back(mk_exec(12, 9'h001, 4'd8, 1'b0, 1'b0, 1'b0, taken ? 4'h2 : 4'h1, "jnz_next"));
            for (int c = 0; c < 13; c++) begin
                while (sb.size() != 0 && int'(sb[0].cyc) == c) begin
                    e = sb.pop_front();
                    total++;
                    if ((obs_vec() & e.mask) !== (e.val & e.mask)) begin
                        bad++;
                        $display("[TB] FAIL %0s r_eq_0=%0d cyc=%0d got=%h want=%h", e.name, r_eq_0, c,
                                 obs_vec() & e.mask, e.val & e.mask);
                    end
                end
                step();
            end
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("[TB] FAIL jnz_leftover got=%0d want=0", sb.size());
            end
        end
        r_eq_0 = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        $display("[TB] test_wrap");
        clear_rom();
        rom[8'h00] = 8'h20;
        rom[8'h01] = 8'hE0;
        rom[8'h02] = 8'hFF;
        rom[8'hFF] = 8'hE0;
        rom[8'h20] = 8'h03;
        do_reset();
        sb.push_back(mk_exec(2, 9'h004, 4'd8, 1'b0, 1'b0, 1'b0, 4'h0, "ldi_y0"));
        sb.push_back(mk_fetch(6, 8'h02, "jaddr02"));
        sb.push_back(mk_fetch(8, 8'hFF, "fetchFF"));
        sb.push_back(mk_fetch(11, 8'h00, "wrap00"));
        sb.push_back(mk_fetch(13, 8'h20, "fetch20"));
        sb.push_back(mk_exec(15, 9'h001, 4'd8, 1'b0, 1'b0, 1'b0, 4'h3, "ldi_x0_3"));
        for (int c = 0; c < 16; c++) begin
            while (sb.size() != 0 && int'(sb[0].cyc) == c) begin
                e = sb.pop_front();
                total++;
                if ((obs_vec() & e.mask) !== (e.val & e.mask)) begin
                    bad++;
                    $display("[TB] FAIL %0s cyc=%0d got=%h want=%h", e.name, c, obs_vec() & e.mask, e.val & e.mask);
                end
            end
            step();
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL wrap_leftover got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'hF0;
        test_reset();
        test_ldi_mov_alu();
        test_back_to_back();
        test_jnz();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
